// File: rtl/dcache_ahb_sram_slave.sv
// rtl/dcache_ahb_sram_slave.sv - AHB-Lite SRAM slave with programmable wait states and two-cycle ERROR
module dcache_ahb_sram_slave #(
    parameter int                     WORD_SIZE   = 32,
    parameter int                     ADDR_LENGTH = 32,
    parameter int                     MEM_BYTES   = 16384,
    parameter logic [ADDR_LENGTH-1:0] BASE_ADDR   = '0,
    parameter int                     WAIT_STATES = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   hsel,
    input  logic [ADDR_LENGTH-1:0] haddr,
    input  logic [1:0]             htrans,
    input  logic                   hwrite,
    input  logic [2:0]             hsize,
    input  logic [2:0]             hburst,
    input  logic [3:0]             hprot,
    input  logic [WORD_SIZE-1:0]   hwdata,
    input  logic                   hready_in,
    output logic                   hreadyout,
    output logic                   hresp,
    output logic [WORD_SIZE-1:0]   hrdata
);

    localparam int LANES   = WORD_SIZE / 8;
    localparam int WORDS   = MEM_BYTES / LANES;
    localparam int IDX_W   = $clog2(WORDS);
    localparam int BYTE_AW = $clog2(MEM_BYTES);
    localparam bit HAS_WAIT = (WAIT_STATES > 0);
    localparam logic [3:0] WS_INIT = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_DATA,
        S_ERR1,
        S_ERR2
    } state_t;

    state_t               state_q, state_d;
    logic [3:0]           wait_cnt_q, wait_cnt_d;
    logic [IDX_W-1:0]     idx_q;
    logic [1:0]           off_q;
    logic [1:0]           size_q;
    logic                 write_q;
    logic                 capture;

    logic [WORD_SIZE-1:0] mem [WORDS];

    logic accept;
    logic in_window;
    logic bad_size;
    logic misaligned;
    logic err_in;
    logic we;
    logic [LANES-1:0] be;

    logic unused_ok;
    assign unused_ok = ^{hburst, hprot, htrans[0]};

    assign accept     = hsel & hready_in & htrans[1];
    // BASE_ADDR is aligned to MEM_BYTES, so the window test is a compare of the upper bits.
    assign in_window  = (haddr[ADDR_LENGTH-1:BYTE_AW] == BASE_ADDR[ADDR_LENGTH-1:BYTE_AW]);
    assign bad_size   = (hsize > 3'd2);
    assign misaligned = ((hsize == 3'd1) && haddr[0]) ||
                        ((hsize == 3'd2) && (haddr[1:0] != 2'b00));
    assign err_in     = !in_window || bad_size || misaligned;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            wait_cnt_q <= 4'd0;
            idx_q      <= '0;
            off_q      <= 2'b00;
            size_q     <= 2'b00;
            write_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            if (capture) begin
                idx_q   <= haddr[BYTE_AW-1:2];
                off_q   <= haddr[1:0];
                size_q  <= hsize[1:0];
                write_q <= hwrite;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        capture    = 1'b0;
        case (state_q)
            S_IDLE, S_DATA, S_ERR2: begin
                state_d = S_IDLE;
                if (accept) begin
                    capture = 1'b1;
                    if (err_in) begin
                        state_d = S_ERR1;
                    end else if (HAS_WAIT) begin
                        state_d    = S_WAIT;
                        wait_cnt_d = WS_INIT;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_WAIT: begin
                if (wait_cnt_q == 4'd0) begin
                    state_d = S_DATA;
                end else begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end
            end
            S_ERR1:  state_d = S_ERR2;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        be = '0;
        case (size_q)
            2'd0:    be[off_q] = 1'b1;
            2'd1:    be = off_q[1] ? 4'b1100 : 4'b0011;
            default: be = '1;
        endcase
    end

    // Reset forces state_q to IDLE asynchronously, so an in-flight write can never commit.
    assign we = (state_q == S_DATA) && write_q;

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < LANES; i++) begin
                if (be[i]) begin
                    mem[idx_q][8*i +: 8] <= hwdata[8*i +: 8];
                end
            end
        end
    end

    assign hreadyout = !((state_q == S_WAIT) || (state_q == S_ERR1));
    assign hresp     = (state_q == S_ERR1) || (state_q == S_ERR2);
    assign hrdata    = ((state_q == S_DATA) && !write_q) ? mem[idx_q] : '0;

endmodule
